// File: rtl/cpu_operand_fetch_pkg.sv
// cpu_pkg: shared register-index and word types for the cpu operand-fetch slice
package cpu_pkg;
  localparam int REG_W = 5;
  localparam int XLEN = 32;
  typedef logic [REG_W-1:0] reg_idx_t;
  typedef logic [XLEN-1:0] word_t;
  localparam reg_idx_t REG_ZERO = '0;
endpackage

// File: rtl/cpu_regfile_mp.sv
// cpu_regfile_mp: multi-read, single-write register file with r0 hard-wired to zero
module cpu_regfile_mp import cpu_pkg::*; #(
  parameter int XLEN = 32,
  parameter int NUM_RD = 2,
  parameter int NUM_REGS = 32
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [NUM_RD*REG_W-1:0] rd_addr,
  output logic [NUM_RD*XLEN-1:0]  rd_data,
  input  logic                   wr_en,
  input  reg_idx_t               wr_addr,
  input  logic [XLEN-1:0]        wr_data
);
  logic [XLEN-1:0] regs [NUM_REGS];
  // contents clear on reset; r0 is never written so it always reads zero
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    else if (wr_en && wr_addr != REG_ZERO) regs[wr_addr] <= wr_data;
  genvar g;
  for (g = 0; g < NUM_RD; g++) begin : g_rd
    assign rd_data[g*XLEN +: XLEN] = regs[rd_addr[g*REG_W +: REG_W]];
  end
endmodule

// File: rtl/cpu_operand_fetch.sv
// cpu_operand_fetch: p2->p3 operand fetch with bypass, hazard stall and p3 hold; optional stall counter via CPU_OPFETCH_STALLCNT_EN
module cpu_operand_fetch import cpu_pkg::*; #(
  parameter int XLEN = 32,
  parameter int NUM_RD = 2,
  parameter int NUM_BYP = 2,
  parameter int NUM_REGS = 32
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     p2_valid,
  input  logic [NUM_RD*REG_W-1:0]  p2_reg,
  input  logic [NUM_RD-1:0]        p2_literal_sel,
  input  logic [NUM_RD*XLEN-1:0]   p2_literal,
  output logic                     p2_stall,
  input  logic [NUM_BYP*REG_W-1:0] byp_reg_d,
  input  logic [NUM_BYP-1:0]       byp_write_en,
  input  logic [NUM_BYP-1:0]       byp_data_ok,
  input  logic [NUM_BYP*XLEN-1:0]  byp_data,
  input  logic                     p3_stall,
  output logic                     p3_valid,
  output logic [NUM_RD*XLEN-1:0]   p3_data,
  output logic [31:0]              stall_count
);
  localparam int WB = NUM_BYP - 1;
  logic [NUM_RD*XLEN-1:0] rf_data;
  logic [NUM_RD*XLEN-1:0] sel_data;
  logic [NUM_RD-1:0] port_haz;
  logic hazard;
  logic hold;
  cpu_regfile_mp #(.XLEN(XLEN), .NUM_RD(NUM_RD), .NUM_REGS(NUM_REGS)) u_rf (
    .clock(clock),
    .reset_n(reset_n),
    .rd_addr(p2_reg),
    .rd_data(rf_data),
    .wr_en(byp_write_en[WB] && byp_data_ok[WB]),
    .wr_addr(byp_reg_d[WB*REG_W +: REG_W]),
    .wr_data(byp_data[WB*XLEN +: XLEN])
  );
  genvar g;
  for (g = 0; g < NUM_RD; g++) begin : g_port
    reg_idx_t r;
    logic hit;
    logic ok;
    logic [XLEN-1:0] d;
    logic lit;
    assign r = p2_reg[g*REG_W +: REG_W];
    assign lit = p2_literal_sel[g];
    // scan oldest to youngest so the youngest matching stage shadows the rest
    always_comb begin
      hit = 1'b0;
      ok = 1'b0;
      d = '0;
      for (int k = NUM_BYP - 1; k >= 0; k--)
        if (byp_write_en[k] && byp_reg_d[k*REG_W +: REG_W] == r) begin
          hit = 1'b1;
          ok = byp_data_ok[k];
          d = byp_data[k*XLEN +: XLEN];
        end
    end
    assign sel_data[g*XLEN +: XLEN] = lit ? p2_literal[g*XLEN +: XLEN] :
                                      r == REG_ZERO ? '0 :
                                      hit ? d : rf_data[g*XLEN +: XLEN];
    assign port_haz[g] = !lit && r != REG_ZERO && hit && !ok;
  end
  assign hazard = p2_valid && |port_haz;
  assign hold = p3_stall && p3_valid;
  assign p2_stall = hazard || hold;
  // p3 holds under execute stall, takes a bubble on hazard, else advances
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      p3_valid <= 1'b0;
      p3_data <= '0;
    end else if (!hold) begin
      p3_valid <= p2_valid && !hazard;
      if (!hazard) p3_data <= sel_data;
    end
`ifdef CPU_OPFETCH_STALLCNT_EN
  logic [31:0] cnt;
  // saturating count of cycles where decode had an instruction but was stalled
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else if (p2_valid && p2_stall && cnt != '1) cnt <= cnt + 32'd1;
  assign stall_count = cnt;
`else
  assign stall_count = '0;
`endif
endmodule

// File: doc/cpu_operand_fetch.md
Name: cpu_operand_fetch

Overview:
- Parametrised operand-fetch stage, sitting between decode (p2) and execute (p3).
- Reads NUM_RD source registers from an internal multi-port register file. Forwards results from NUM_BYP in-flight stages using internal register-number compares; there are no external bypass flags.
- Per port, an optional literal can replace the register operand.
- Detects hazards where a matching producer has not yet got its result (e.g. load-use) and stalls decode.
- Holds p3 operands while execute is stalled.

Parameters:
- XLEN, 32, data width in bits.
- NUM_RD, 2, number of source operand ports (1..4).
- NUM_BYP, 2, number of bypass sources. Index 0 is the youngest (p3). Index NUM_BYP-1 is writeback (p4) and also drives the register-file write.
- NUM_REGS, 32, number of architectural registers. r0 is hard-wired to zero.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- p2_valid  in  1  decode presents an instruction
- p2_reg  in  NUM_RD*5  source register numbers, port i in bits [5i+4:5i]
- p2_literal_sel  in  NUM_RD  port i takes its literal instead of a register
- p2_literal  in  NUM_RD*XLEN  literal values
- p2_stall  out  1  decode must hold its current instruction
- byp_reg_d  in  NUM_BYP*5  destination register per bypass stage
- byp_write_en  in  NUM_BYP  stage will write its destination register
- byp_data_ok  in  NUM_BYP  stage's result is available this cycle
- byp_data  in  NUM_BYP*XLEN  stage result data
- p3_stall  in  1  execute cannot accept a new operand set
- p3_valid  out  1  p3_data holds a valid operand set
- p3_data  out  NUM_RD*XLEN  registered operands
- stall_count  out  32  stall-cycle counter (only with the optional feature)

Behaviour:
- Reset: asynchronous on reset_n low. p3_valid=0, p3_data=0, stall_count=0, register file cleared to 0.
- Latency: one cycle from p2 to p3 when there is no stall.
- Per-port operand select, first match wins:
  1. literal_sel set: use the literal.
  2. reg == 0: use 0; bypass is never used for r0.
  3. Lowest bypass index k with byp_write_en[k] and byp_reg_d[k] == reg: if byp_data_ok[k], use byp_data[k]; otherwise the port is a hazard.
  4. No match: use the register-file read value.
- A younger bypass stage always shadows an older one, even when the younger stage's data is not ready.
- Register file:
  - NUM_RD combinational read ports.
  - One write port, fed by bypass stage NUM_BYP-1 when byp_write_en and byp_data_ok are set and reg_d != 0. Written on the rising clock edge.
  - A read of the same register in the same cycle returns the old value; writeback bypass supplies the new one.
- hazard = p2_valid AND any port is a hazard.
- p2_stall = hazard OR (p3_stall AND p3_valid).
- Pipeline register update, every rising edge:
  - p3_stall AND p3_valid: hold p3_valid and p3_data unchanged.
  - Otherwise hazard: p3_valid <= 0, which inserts a bubble; p3_data is don't-care, so hold it.
  - Otherwise: p3_valid <= p2_valid and p3_data <= selected operands.
- p3_stall while p3_valid=0 is ignored: the bubble is overwritten and no deadlock results.
- Held operands are not re-forwarded. Producers feeding the held instruction are already past it, so the captured values stay correct.
- Reset asserted mid-stall clears p3_valid immediately; p2_stall then follows from the inputs alone.

Optional Feature:
- Macro: CPU_OPFETCH_STALLCNT_EN.
- Defined: stall_count increments by 1 on each clock edge where p2_valid AND p2_stall. It saturates at 0xFFFFFFFF and resets to 0.
- Not defined: stall_count is tied to 0 and no counter flops are built.

Decomposition:
- Package cpu_pkg holds:
  - REG_W=5.
  - typedef reg_idx_t (logic [4:0]).
  - typedef word_t (logic [XLEN-1:0]), with XLEN defaulting to 32.
  - localparam REG_ZERO=0.
- Sub-module cpu_regfile_mp: NUM_RD combinational reads, one synchronous write, async-reset contents, r0 never written.
- Operand select is a generate loop over ports, with a priority loop over bypass stages.

Test Plan:
- Write r5=0x1234 via stage1 (ok=1), no p3 match; next cycle read r5 on port0 -> p3_data[0]=0x1234 one cycle later, p2_stall=0.
- Stage0 reg_d=7 data=0xAAAA ok=1, and stage1 reg_d=7 data=0xBBBB ok=1, read r7 -> 0xAAAA (younger wins). Repeat with stage0 ok=0 -> p2_stall=1, p3_valid=0 next cycle.
- Load-use: stage0 reg_d=3 ok=0 for one cycle, then the stage moves to stage1 with ok=1 data=0x55 -> exactly one bubble, then p3_data=0x55, p3_valid=1.
- Read r0 while stage0 reg_d=0 write_en=1 data=0xFFFF -> operand 0; set literal_sel on port1 with literal 0x10 -> p3_data[1]=0x10 regardless of bypass.
- Hold: p3_valid=1 with p3_stall=1 for 3 cycles while inputs change -> p3_data unchanged, p2_stall=1. With the macro, stall_count rises by 3.
- Assert reset_n=0 mid-hold -> p3_valid=0 and p3_data=0 immediately (asynchronous); all register reads return 0 after release.
